// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise, deglitch and deframe device-to-host frames, then fold E0/F0 prefixes into flags.
// Optional macro PS2_RX_TYPEMATIC_FILTER_EN suppresses repeated make codes until the key is released.
module ps2_scancode_rx #(
  parameter int unsigned clk_mhz    = 25,
  parameter int unsigned timeout_us = 2000,
  parameter int unsigned filter_len = 8
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned WdLimit = clk_mhz * timeout_us;
  localparam int unsigned WdW     = $clog2(WdLimit + 1);
  localparam int unsigned FiltW   = 5;
  localparam logic [FiltW-1:0] FiltLast = FiltW'(filter_len - 1);
  localparam logic [WdW-1:0]   WdLast   = WdW'(WdLimit - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [1:0] clkSync_q, dataSync_q;
  logic [1:0] syncd;
  logic [1:0] filt_q, filt_d;
  logic [1:0][FiltW-1:0] filtCnt_q, filtCnt_d;

  state_e       state_q;
  logic [2:0]   bitCnt_q;
  logic [7:0]   shift_q;
  logic         parity_q;
  logic [WdW-1:0] wd_q;
  logic         ext_q, brk_q;
  logic [7:0]   code_q;
  logic         codeValid_q, isBreak_q, isExt_q, parityErr_q, frameErr_q;

  logic fallEvent, dataBit, parityOk, repeatMake;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      filt_q     <= 2'b11;
      filtCnt_q  <= '0;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2clk};
      dataSync_q <= {dataSync_q[0], ps2data};
      filt_q     <= filt_d;
      filtCnt_q  <= filtCnt_d;
    end
  end

  assign syncd = {dataSync_q[1], clkSync_q[1]};

  // Index 0 is the clock line, index 1 the data line; a flip needs filter_len disagreeing samples.
  always_comb begin
    filt_d    = filt_q;
    filtCnt_d = filtCnt_q;
    for (int i = 0; i < 2; i++) begin
      if (syncd[i] == filt_q[i]) begin
        filtCnt_d[i] = '0;
      end else if (filtCnt_q[i] == FiltLast) begin
        filt_d[i]    = syncd[i];
        filtCnt_d[i] = '0;
      end else begin
        filtCnt_d[i] = filtCnt_q[i] + FiltW'(1);
      end
    end
  end

  assign fallEvent = filt_q[0] & ~filt_d[0];
  assign dataBit   = filt_q[1];
  assign parityOk  = ^{shift_q, parity_q};

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  logic [7:0] lastCode_q;
  logic       lastExt_q, lastArmed_q;

  assign repeatMake = !brk_q && lastArmed_q && (lastCode_q == shift_q) && (lastExt_q == ext_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lastCode_q  <= 8'h00;
      lastExt_q   <= 1'b0;
      lastArmed_q <= 1'b0;
    end else if (fallEvent && state_q == STOP && dataBit && parityOk &&
                 shift_q != 8'hE0 && shift_q != 8'hF0) begin
      if (brk_q) begin
        if (lastArmed_q && lastCode_q == shift_q && lastExt_q == ext_q) begin
          lastArmed_q <= 1'b0;
        end
      end else begin
        lastCode_q  <= shift_q;
        lastExt_q   <= ext_q;
        lastArmed_q <= 1'b1;
      end
    end
  end
`else
  assign repeatMake = 1'b0;
`endif

  // A fall event always takes priority over watchdog expiry and restarts the gap count.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      bitCnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      wd_q        <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      code_q      <= 8'h00;
      codeValid_q <= 1'b0;
      isBreak_q   <= 1'b0;
      isExt_q     <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      codeValid_q <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
      if (fallEvent) begin
        wd_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dataBit) begin
              state_q  <= DATA;
              bitCnt_q <= 3'd0;
            end
          end
          DATA: begin
            shift_q  <= {dataBit, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= dataBit;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!dataBit) begin
              frameErr_q <= 1'b1;
              ext_q      <= 1'b0;
              brk_q      <= 1'b0;
            end else if (!parityOk) begin
              parityErr_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end else if (shift_q == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_q <= 1'b1;
            end else begin
              if (!repeatMake) begin
                code_q      <= shift_q;
                isBreak_q   <= brk_q;
                isExt_q     <= ext_q;
                codeValid_q <= 1'b1;
              end
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (wd_q == WdLast) begin
          wd_q       <= '0;
          state_q    <= IDLE;
          frameErr_q <= 1'b1;
          ext_q      <= 1'b0;
          brk_q      <= 1'b0;
        end else begin
          wd_q <= wd_q + WdW'(1);
        end
      end
    end
  end

  assign code        = code_q;
  assign code_valid  = codeValid_q;
  assign is_break    = isBreak_q;
  assign is_extended = isExt_q;
  assign parity_err  = parityErr_q;
  assign frame_err   = frameErr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames push expected events, a monitor pops and compares.
module tb_ps2_scancode_rx;

  localparam int ClkMhz    = 1;
  localparam int TimeoutUs = 200;
  localparam int FilterLen = 8;
  localparam int Half      = 20;
  localparam int TimeoutLatency = 2 + FilterLen + ClkMhz * TimeoutUs;

  localparam logic [1:0] KCode = 2'd0;
  localparam logic [1:0] KPar  = 2'd1;
  localparam logic [1:0] KFrm  = 2'd2;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] code;
  logic       code_valid, is_break, is_extended, parity_err, frame_err;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastFallCyc = 0;

  ps2_scancode_rx #(
    .clk_mhz(ClkMhz),
    .timeout_us(TimeoutUs),
    .filter_len(FilterLen)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .ps2clk(ps2clk),
    .ps2data(ps2data),
    .code(code),
    .code_valid(code_valid),
    .is_break(is_break),
    .is_extended(is_extended),
    .parity_err(parity_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [1:0] kind, input logic [7:0] c, input logic b, input logic e);
    exp_t x;
    x.kind = kind;
    x.code = c;
    x.brk  = b;
    x.ext  = e;
    expQ.push_back(x);
  endtask

  task automatic sendBit(input logic b, input bit glitch);
    ps2data = b;
    if (glitch) begin
      tick(8);
      ps2clk = 1'b0;
      tick(3);
      ps2clk = 1'b1;
      tick(Half - 11);
    end else begin
      tick(Half);
    end
    ps2clk = 1'b0;
    lastFallCyc = cyc;
    tick(Half);
    ps2clk = 1'b1;
  endtask

  // Sends one 11-bit frame; flipPar inverts the odd parity bit, glitchBit (<11) injects a clock glitch before that bit.
  task automatic applyStimulus(input logic [7:0] b, input bit flipPar, input logic stopBit, input int glitchBit);
    logic [10:0] frame;
    frame = {stopBit, (~^b) ^ flipPar, b, 1'b0};
    for (int i = 0; i < 11; i++) sendBit(frame[i], glitchBit == i);
    ps2data = 1'b1;
    tick(2 * Half);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_code"}, {24'h0, code}, 32'h00);
    checkOutput({tag, "_code_valid"}, {31'h0, code_valid}, 32'h0);
    checkOutput({tag, "_is_break"}, {31'h0, is_break}, 32'h0);
    checkOutput({tag, "_is_extended"}, {31'h0, is_extended}, 32'h0);
    checkOutput({tag, "_parity_err"}, {31'h0, parity_err}, 32'h0);
    checkOutput({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
  endtask

  // Monitor: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (code_valid || parity_err || frame_err) begin
      logic [11:0] act;
      logic [11:0] want;
      if (code_valid)      act = {KCode, code, is_break, is_extended};
      else if (parity_err) act = {KPar, 10'h0};
      else                 act = {KFrm, 10'h0};
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedStrobe: got %03h, expected none", act);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        want = (e.kind == KCode) ? {e.kind, e.code, e.brk, e.ext} : {e.kind, 10'h0};
        if (act !== want) begin
          errors++;
          $display("[TB] FAIL strobe: got %03h, expected %03h", act, want);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    bit seen;
    int lat;
    tick(5);
    checkResetValues("reset");
    n_reset = 1'b1;
    tick(40);

    pushExp(KCode, 8'h1C, 1'b0, 1'b0);
    applyStimulus(8'h1C, 0, 1'b1, 99);

    pushExp(KCode, 8'h1C, 1'b1, 1'b0);
    applyStimulus(8'hF0, 0, 1'b1, 99);
    applyStimulus(8'h1C, 0, 1'b1, 99);

    pushExp(KCode, 8'h75, 1'b1, 1'b1);
    applyStimulus(8'hE0, 0, 1'b1, 99);
    applyStimulus(8'hF0, 0, 1'b1, 99);
    applyStimulus(8'h75, 0, 1'b1, 99);

    pushExp(KPar, 8'h00, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1, 1'b1, 99);
    pushExp(KCode, 8'h1C, 1'b0, 1'b0);
    applyStimulus(8'h1C, 0, 1'b1, 99);

    pushExp(KPar, 8'h00, 1'b0, 1'b0);
    pushExp(KCode, 8'h15, 1'b0, 1'b0);
    applyStimulus(8'hE0, 0, 1'b1, 99);
    applyStimulus(8'h1C, 1, 1'b1, 99);
    applyStimulus(8'h15, 0, 1'b1, 99);

    pushExp(KFrm, 8'h00, 1'b0, 1'b0);
    applyStimulus(8'h1C, 0, 1'b0, 99);

    pushExp(KFrm, 8'h00, 1'b0, 1'b0);
    sendBit(1'b0, 0);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 0);
    seen = 0;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_err) begin
        seen = 1;
        lat = cyc - lastFallCyc;
        break;
      end
    end
    checkOutput("timeoutLatency", seen ? lat : -1, TimeoutLatency);
    tick(20);
    pushExp(KCode, 8'h2A, 1'b0, 1'b0);
    applyStimulus(8'h2A, 0, 1'b1, 99);

    ps2clk = 1'b0;
    tick(3);
    ps2clk = 1'b1;
    tick(40);
    pushExp(KCode, 8'h33, 1'b0, 1'b0);
    applyStimulus(8'h33, 0, 1'b1, 99);
    pushExp(KCode, 8'h4B, 1'b0, 1'b0);
    applyStimulus(8'h4B, 0, 1'b1, 4);

    sendBit(1'b0, 0);
    sendBit(1'b1, 0);
    sendBit(1'b0, 0);
    ps2data = 1'b1;
    tick(5);
    n_reset = 1'b0;
    tick(3);
    checkResetValues("midReset");
    n_reset = 1'b1;
    tick(60);
    pushExp(KCode, 8'h29, 1'b0, 1'b0);
    applyStimulus(8'h29, 0, 1'b1, 99);

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
    pushExp(KCode, 8'h1C, 1'b0, 1'b0);
    pushExp(KCode, 8'h1C, 1'b1, 1'b0);
    pushExp(KCode, 8'h1C, 1'b0, 1'b0);
`else
    pushExp(KCode, 8'h1C, 1'b0, 1'b0);
    pushExp(KCode, 8'h1C, 1'b0, 1'b0);
    pushExp(KCode, 8'h1C, 1'b0, 1'b0);
    pushExp(KCode, 8'h1C, 1'b1, 1'b0);
    pushExp(KCode, 8'h1C, 1'b0, 1'b0);
`endif
    applyStimulus(8'h1C, 0, 1'b1, 99);
    applyStimulus(8'h1C, 0, 1'b1, 99);
    applyStimulus(8'h1C, 0, 1'b1, 99);
    applyStimulus(8'hF0, 0, 1'b1, 99);
    applyStimulus(8'h1C, 0, 1'b1, 99);
    applyStimulus(8'h1C, 0, 1'b1, 99);

    tick(100);
    checkOutput("pendingExpected", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
